// File: rtl/sequence_timer_gen.sv
// Timing-state sequencer: T counter gated by start/stop flop S, hold stall, registered opcode->D decode.
// One-edge latency on state/S/D; SEQ_TIMEOUT_EN turns terminal roll-over into saturate + sticky timeout.
module sequence_timer_gen #(
  parameter  int NUM_STATES = 16,
  parameter  int OPC_W      = 3,
  localparam int CNT_W      = $clog2(NUM_STATES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  clr,
  input  logic                  hold,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  load_opc,
  input  logic [OPC_W-1:0]      opcode,
  output logic [CNT_W-1:0]      state,
  output logic [NUM_STATES-1:0] t_onehot,
  output logic [2**OPC_W-1:0]   d_onehot,
  output logic                  S,
  output logic                  wrap,
  output logic                  timeout
);

  localparam int               D_W  = 2**OPC_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_STATES - 1);

  logic advance;
  assign advance = inc && S && !hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= '0;
      S        <= 1'b0;
      d_onehot <= D_W'(1);
      wrap     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      wrap <= 1'b0;

      if (halt)
        S <= 1'b0;
      else if (start)
        S <= 1'b1;

      if (load_opc)
        d_onehot <= D_W'(1) << opcode;

      // clr outranks everything except reset, even with S low or hold high
      if (clr) begin
        state <= '0;
      end else if (advance) begin
        if (state == LAST) begin
`ifdef SEQ_TIMEOUT_EN
          timeout <= 1'b1;
`else
          state   <= '0;
          wrap    <= 1'b1;
`endif
        end else begin
          state <= state + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    t_onehot = '0;
    for (int k = 0; k < NUM_STATES; k++)
      t_onehot[k] = (state == CNT_W'(k));
  end

endmodule

// File: tb/tb_sequence_timer_gen.sv
// Bench for sequence_timer_gen: table vectors, directed corner sequences, and randomized run vs a reference model.
module tb_sequence_timer_gen;

  logic       clk = 1'b0;
  logic       reset, inc, clr, hold, start, halt, load_opc;
  logic [2:0] opcode;

  logic [3:0]  state16, state10;
  logic [15:0] t16;
  logic [9:0]  t10;
  logic [7:0]  d16, d10;
  logic        s16, s10, wrap16, wrap10, to16, to10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sequence_timer_gen #(.NUM_STATES(16), .OPC_W(3)) dut16 (
    .clk(clk), .reset(reset), .inc(inc), .clr(clr), .hold(hold), .start(start),
    .halt(halt), .load_opc(load_opc), .opcode(opcode), .state(state16),
    .t_onehot(t16), .d_onehot(d16), .S(s16), .wrap(wrap16), .timeout(to16));

  sequence_timer_gen #(.NUM_STATES(10), .OPC_W(3)) dut10 (
    .clk(clk), .reset(reset), .inc(inc), .clr(clr), .hold(hold), .start(start),
    .halt(halt), .load_opc(load_opc), .opcode(opcode), .state(state10),
    .t_onehot(t10), .d_onehot(d10), .S(s10), .wrap(wrap10), .timeout(to10));

  // Reference model: index 0 models 16 states, index 1 models 10 states.
  int       m_st  [2];
  bit       m_s   [2];
  bit       m_wrap[2];
  bit       m_to  [2];
  int       m_d   [2];
  const int m_n   [2] = '{16, 10};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_st[i] = 0; m_s[i] = 0; m_wrap[i] = 0; m_to[i] = 0; m_d[i] = 1;
      end else begin
        bit accepted;
        accepted  = inc && m_s[i] && !hold;
        m_wrap[i] = 0;
        if (clr)
          m_st[i] = 0;
        else if (accepted) begin
          if (m_st[i] == m_n[i] - 1) begin
`ifdef SEQ_TIMEOUT_EN
            m_to[i] = 1;
`else
            m_st[i] = 0;
            m_wrap[i] = 1;
`endif
          end else
            m_st[i] = m_st[i] + 1;
        end
        if (halt) m_s[i] = 0;
        else if (start) m_s[i] = 1;
        if (load_opc) m_d[i] = 1 << opcode;
      end
    end
  endtask

  task automatic compare_all();
    chk("state16", 64'(state16), 64'(m_st[0]));
    chk("t16",     64'(t16),     64'(1) << m_st[0]);
    chk("d16",     64'(d16),     64'(m_d[0]));
    chk("S16",     64'(s16),     64'(m_s[0]));
    chk("wrap16",  64'(wrap16),  64'(m_wrap[0]));
    chk("to16",    64'(to16),    64'(m_to[0]));
    chk("state10", 64'(state10), 64'(m_st[1]));
    chk("t10",     64'(t10),     64'(1) << m_st[1]);
    chk("d10",     64'(d10),     64'(m_d[1]));
    chk("S10",     64'(s10),     64'(m_s[1]));
    chk("wrap10",  64'(wrap10),  64'(m_wrap[1]));
    chk("to10",    64'(to10),    64'(m_to[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    reset = 0; inc = 0; clr = 0; hold = 0; start = 0; halt = 0; load_opc = 0; opcode = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  typedef struct {
    logic       inc, clr, hold, start, halt, load;
    logic [2:0] opc;
    int         exp_state;
    logic       exp_s;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[12];

  initial begin
    //          inc clr hold st halt ld opc   state S  d
    vecs[0]  = '{0, 0, 0, 1, 0, 0, 3'd0, 0, 1, 8'h01};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 3'd0, 1, 1, 8'h01};
    vecs[2]  = '{1, 0, 0, 0, 0, 0, 3'd0, 2, 1, 8'h01};
    vecs[3]  = '{1, 0, 1, 0, 0, 0, 3'd0, 2, 1, 8'h01};
    vecs[4]  = '{1, 1, 0, 0, 0, 0, 3'd0, 0, 1, 8'h01};
    vecs[5]  = '{0, 0, 0, 0, 0, 1, 3'd5, 0, 1, 8'h20};
    vecs[6]  = '{1, 0, 0, 0, 0, 0, 3'd3, 1, 1, 8'h20};
    vecs[7]  = '{1, 0, 0, 1, 1, 0, 3'd3, 2, 0, 8'h20};
    vecs[8]  = '{1, 0, 0, 0, 0, 0, 3'd6, 2, 0, 8'h20};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 3'd6, 0, 0, 8'h20};
    vecs[10] = '{0, 0, 0, 1, 0, 0, 3'd6, 0, 1, 8'h20};
    vecs[11] = '{1, 0, 0, 0, 0, 1, 3'd7, 1, 1, 8'h80};

    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    chk("rst_state", 64'(state16), 64'(0));
    chk("rst_t",     64'(t16),     64'(1));
    chk("rst_d",     64'(d16),     64'(1));
    chk("rst_S",     64'(s16),     64'(0));
    chk("rst_wrap",  64'(wrap16),  64'(0));
    chk("rst_to",    64'(to16),    64'(0));

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      inc = vecs[i].inc; clr = vecs[i].clr; hold = vecs[i].hold; start = vecs[i].start;
      halt = vecs[i].halt; load_opc = vecs[i].load; opcode = vecs[i].opc;
      tick();
      chk($sformatf("vec%0d_state", i), 64'(state16), 64'(vecs[i].exp_state));
      chk($sformatf("vec%0d_S", i),     64'(s16),     64'(vecs[i].exp_s));
      chk($sformatf("vec%0d_d", i),     64'(d16),     64'(vecs[i].exp_d));
    end

    // Full run from T0 with continuous inc: terminal-state behaviour
    do_reset();
    start = 1; tick(); start = 0;
    inc = 1;
    for (int i = 0; i < 9; i++) tick();
    chk("n10_at9", 64'(state10), 64'(9));
    tick();
`ifdef SEQ_TIMEOUT_EN
    chk("n10_sat",  64'(state10), 64'(9));
    chk("n10_to",   64'(to10),    64'(1));
    chk("n10_wrap", 64'(wrap10),  64'(0));
`else
    chk("n10_wrap0",  64'(state10), 64'(0));
    chk("n10_wrap",   64'(wrap10),  64'(1));
    tick();
    chk("n10_wrap_1c", 64'(wrap10), 64'(0));
`endif
    while (state16 != 4'd15 && checks < 100000) tick();
    chk("n16_at15", 64'(state16), 64'(15));
    tick();
`ifdef SEQ_TIMEOUT_EN
    chk("n16_sat", 64'(state16), 64'(15));
    chk("n16_to",  64'(to16),    64'(1));
    inc = 0; clr = 1; tick(); clr = 0;
    chk("to_sticky_clr", 64'(to16), 64'(1));
    chk("clr_state",     64'(state16), 64'(0));
    reset = 1; tick(); reset = 0;
    chk("to_reset", 64'(to16), 64'(0));
`else
    chk("n16_wrap0", 64'(state16), 64'(0));
    chk("n16_wrap",  64'(wrap16),  64'(1));
    chk("n16_to",    64'(to16),    64'(0));
`endif

    // Hold at state 5, then clr together with inc
    do_reset();
    start = 1; tick(); start = 0;
    inc = 1;
    for (int i = 0; i < 5; i++) tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_state", 64'(state16), 64'(5));
    end
    hold = 0; clr = 1; tick(); clr = 0;
    chk("clr_inc_state", 64'(state16), 64'(0));
    chk("clr_inc_wrap",  64'(wrap16),  64'(0));

    // halt+start at state 3, then clr with S low
    inc = 1;
    for (int i = 0; i < 3; i++) tick();
    inc = 0; halt = 1; start = 1; tick(); halt = 0; start = 0;
    chk("halt_wins_S", 64'(s16), 64'(0));
    inc = 1; tick(); tick();
    chk("frozen_state", 64'(state16), 64'(3));
    inc = 0; clr = 1; tick(); clr = 0;
    chk("clr_S0_state", 64'(state16), 64'(0));
    chk("clr_S0_S",     64'(s16),     64'(0));

    // Decoder holds while load_opc low
    load_opc = 1; opcode = 3'b101; tick(); load_opc = 0;
    chk("dec_load", 64'(d16), 64'h20);
    opcode = 3'b010; tick(); opcode = 3'b111; tick();
    chk("dec_hold", 64'(d16), 64'h20);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      inc      = ($urandom_range(0, 9) < 8);
      clr      = ($urandom_range(0, 39) == 0);
      hold     = ($urandom_range(0, 9) == 0);
      start    = ($urandom_range(0, 9) == 0);
      halt     = ($urandom_range(0, 49) == 0);
      load_opc = ($urandom_range(0, 7) == 0);
      opcode   = 3'($urandom_range(0, 7));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
